syn_access_sequencer: RTL and testbench
=======================================

// Module: syn_access_sequencer
// PURPOSE
//  Sequences and arbitrates all accesses to the 8192x32 synaptic SRAM inside synaptic_core.
//  Two requesters share the array: AER synaptic events (32-word sweep of one pre-neuron row,
//  optional SDSP read-modify-write) and SPI programming (single-word read or masked RMW write).
//  Drives CTRL_SYNARRAY_CS/WE/ADDR and CTRL_PRE_EN; flags each valid read word to the neuron side.
// PARAMETERS
//  WORDS_PER_PRE  32  words per pre-neuron row; ADDR = {pre[7:0], word[4:0]}
//  ADDR_W         13  synaptic SRAM address width
// PORTS
//  CLK                     in   1   clock; all state updates on rising edge
//  RST                     in   1   asynchronous reset, active-high
//  SPI_GATE_ACTIVITY_sync  in   1   1 = SPI owns array, events held off
//  EVT_REQ                 in   1   event request; level, held until EVT_ACK
//  EVT_PRE_ADDR            in   8   pre-neuron index; stable while EVT_REQ=1
//  EVT_PLASTIC             in   1   1 = SDSP write-back of every word of the row
//  EVT_ACK                 out  1   1-cycle pulse, event fully done
//  SPI_REQ                 in   1   SPI access request; level, held until SPI_ACK
//  SPI_WR                  in   1   1 = masked write (RMW), 0 = read
//  SPI_ADDR                in   13  word address; stable while SPI_REQ=1
//  SPI_ACK                 out  1   1-cycle pulse, access done
//  SPI_RDATA               out  32  read data captured on SPI read
//  SYNARRAY_RDATA          in   32  SRAM Q (registered, 1-cycle read latency)
//  CTRL_SYNARRAY_CS        out  1   SRAM chip select
//  CTRL_SYNARRAY_WE        out  1   SRAM write enable
//  CTRL_SYNARRAY_ADDR      out  13  SRAM address
//  CTRL_PRE_EN             out  8   SDSP per-synapse enable to synaptic_core
//  SYN_WORD_VALID          out  1   SYNARRAY_RDATA holds event word SYN_WORD_IDX
//  SYN_WORD_IDX            out  5   word index of current valid word
//  EVT_COUNT               out  16  completed-event counter (optional feature)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0, SPI_RDATA=0, word counter=0, EVT_COUNT=0.
//  - States: IDLE, EVT_RD, EVT_WR, EVT_LAST, SPI_RD, SPI_WR, SPI_DONE.
//  - IDLE arbitration, fixed, non-preemptive: SPI_REQ & gate -> SPI_RD; else EVT_REQ & ~gate
//    -> EVT_RD, word=0. SPI_REQ with gate=0 and EVT_REQ with gate=1 wait (no ACK, no access).
//  - EVT_RD: CS=1, WE=0, ADDR={EVT_PRE_ADDR,word}. Next: EVT_PLASTIC ? EVT_WR : read next word.
//  - Non-plastic: back-to-back reads, word++ each cycle; after word 31 read -> EVT_LAST
//    (1 cycle, CS=0, exposes last word). Total 33 cycles REQ-seen to ACK.
//  - Plastic: EVT_WR same ADDR, CS=1, WE=1, CTRL_PRE_EN=8'hFF (RDATA valid this cycle,
//    WDATA from sdsp_update); then word++ -> EVT_RD, or after word 31 -> IDLE. 64 cycles.
//  - SYN_WORD_VALID=1 in the cycle after each event read (EVT_WR, next EVT_RD, or EVT_LAST),
//    SYN_WORD_IDX = word read previous cycle. CTRL_PRE_EN=0 in all other states.
//  - EVT_ACK pulses in the cycle entering IDLE after an event; SPI_ACK likewise after SPI.
//  - SPI_RD: CS=1, WE=0, ADDR=SPI_ADDR; next SPI_WR if SPI_WR else SPI_DONE.
//  - SPI_WR: CS=1, WE=1, same ADDR (synaptic_core applies mask to RDATA); -> IDLE, SPI_ACK.
//  - SPI_DONE: CS=0, SPI_RDATA <= SYNARRAY_RDATA; -> IDLE, SPI_ACK.
//  - Gate toggling mid-event: event runs to completion; gate sampled only in IDLE.
//  - Word counter wraps 31->0 only at event end; no partial rows.
//  - REQ deasserted mid-access (protocol violation): access still completes, ACK still pulses.
//  - RST mid-operation: immediate return to IDLE, in-flight write abandoned, no ACK.
// CONFIGURATION
//  - SYNSEQ_EVT_CNT_EN defined: EVT_COUNT increments on each EVT_ACK, saturates at 16'hFFFF;
//    cleared only by RST.
//  - Not defined: counter not built, EVT_COUNT tied to 16'h0000.
// TESTING
//  - Event pre=8'h05, EVT_PLASTIC=0 -> 32 reads ADDR 0x0A0..0x0BF, WE never 1, ACK 33 cycles on.
//  - Event pre=8'hFF, EVT_PLASTIC=1 -> alternating RD/WR ADDR 0x1FE0..0x1FFF, PRE_EN=FF on WR only,
//    32 writes, ACK at cycle 64, SYN_WORD_IDX 0..31 in order.
//  - Gate=1, SPI read 0x0123 preloaded 0xDEADBEEF -> SPI_RDATA=0xDEADBEEF, SPI_ACK, no WE.
//  - Gate=1, EVT_REQ and SPI write 0x0040 same cycle -> SPI served (RD,WR), event stalled until
//    gate=0, then event runs.
//  - Gate rises at word 10 of plastic event -> event finishes all 32 words before SPI served.
//  - RST pulse at word 7 -> outputs 0 next edge; with SYNSEQ_EVT_CNT_EN, 3 events -> EVT_COUNT=3.

Source files
------------

// File: rtl/syn_access_sequencer.sv
// rtl/syn_access_sequencer.sv - synaptic SRAM access sequencer/arbiter (AER events vs SPI programming)
// Optional completed-event counter enabled by defining SYNSEQ_EVT_CNT_EN.
module syn_access_sequencer #(
    parameter int WORDS_PER_PRE = 32,
    parameter int ADDR_W        = 13
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             SPI_GATE_ACTIVITY_sync,
    input  logic                             EVT_REQ,
    input  logic [7:0]                       EVT_PRE_ADDR,
    input  logic                             EVT_PLASTIC,
    output logic                             EVT_ACK,
    input  logic                             SPI_REQ,
    input  logic                             SPI_WR,
    input  logic [ADDR_W-1:0]                SPI_ADDR,
    output logic                             SPI_ACK,
    output logic [31:0]                      SPI_RDATA,
    input  logic [31:0]                      SYNARRAY_RDATA,
    output logic                             CTRL_SYNARRAY_CS,
    output logic                             CTRL_SYNARRAY_WE,
    output logic [ADDR_W-1:0]                CTRL_SYNARRAY_ADDR,
    output logic [7:0]                       CTRL_PRE_EN,
    output logic                             SYN_WORD_VALID,
    output logic [$clog2(WORDS_PER_PRE)-1:0] SYN_WORD_IDX,
    output logic [15:0]                      EVT_COUNT
);

    localparam int WORD_W = $clog2(WORDS_PER_PRE);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_PRE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EVT_RD, S_EVT_WR, S_EVT_LAST, S_SPI_RD, S_SPI_WR, S_SPI_DONE
    } state_t;

    state_t              state, state_n;
    logic [WORD_W-1:0]   word, word_n;
    logic                capture;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= S_IDLE;
            word           <= '0;
            SYN_WORD_VALID <= 1'b0;
            SYN_WORD_IDX   <= '0;
            SPI_RDATA      <= '0;
        end else begin
            state          <= state_n;
            word           <= word_n;
            // SRAM Q is one cycle behind the address, so the valid flag trails each event read.
            SYN_WORD_VALID <= (state == S_EVT_RD);
            SYN_WORD_IDX   <= word;
            if (capture)
                SPI_RDATA <= SYNARRAY_RDATA;
        end
    end

    always_comb begin
        state_n            = state;
        word_n             = word;
        CTRL_SYNARRAY_CS   = 1'b0;
        CTRL_SYNARRAY_WE   = 1'b0;
        CTRL_SYNARRAY_ADDR = '0;
        CTRL_PRE_EN        = 8'h00;
        EVT_ACK            = 1'b0;
        SPI_ACK            = 1'b0;
        capture            = 1'b0;
        case (state)
            S_IDLE: begin
                if (SPI_REQ && SPI_GATE_ACTIVITY_sync) begin
                    state_n = S_SPI_RD;
                end else if (EVT_REQ && !SPI_GATE_ACTIVITY_sync) begin
                    state_n = S_EVT_RD;
                    word_n  = '0;
                end
            end
            S_EVT_RD: begin
                CTRL_SYNARRAY_CS   = 1'b1;
                CTRL_SYNARRAY_ADDR = {EVT_PRE_ADDR, word};
                if (EVT_PLASTIC) begin
                    state_n = S_EVT_WR;
                end else begin
                    word_n = word + 1'b1;
                    if (word == LAST_WORD)
                        state_n = S_EVT_LAST;
                end
            end
            S_EVT_WR: begin
                CTRL_SYNARRAY_CS   = 1'b1;
                CTRL_SYNARRAY_WE   = 1'b1;
                CTRL_SYNARRAY_ADDR = {EVT_PRE_ADDR, word};
                CTRL_PRE_EN        = 8'hFF;
                word_n             = word + 1'b1;
                if (word == LAST_WORD) begin
                    state_n = S_IDLE;
                    EVT_ACK = 1'b1;
                end else begin
                    state_n = S_EVT_RD;
                end
            end
            S_EVT_LAST: begin
                EVT_ACK = 1'b1;
                state_n = S_IDLE;
            end
            S_SPI_RD: begin
                CTRL_SYNARRAY_CS   = 1'b1;
                CTRL_SYNARRAY_ADDR = SPI_ADDR;
                state_n            = SPI_WR ? S_SPI_WR : S_SPI_DONE;
            end
            S_SPI_WR: begin
                CTRL_SYNARRAY_CS   = 1'b1;
                CTRL_SYNARRAY_WE   = 1'b1;
                CTRL_SYNARRAY_ADDR = SPI_ADDR;
                SPI_ACK            = 1'b1;
                state_n            = S_IDLE;
            end
            S_SPI_DONE: begin
                capture = 1'b1;
                SPI_ACK = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef SYNSEQ_EVT_CNT_EN
    logic [15:0] evt_count_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            evt_count_q <= '0;
        else if (EVT_ACK && evt_count_q != 16'hFFFF)
            evt_count_q <= evt_count_q + 16'd1;
    end

    assign EVT_COUNT = evt_count_q;
`else
    assign EVT_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_syn_access_sequencer.sv
// tb/tb_syn_access_sequencer.sv - randomized bench with transaction-level reference model
module tb_syn_access_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SPI_GATE_ACTIVITY_sync = 1'b0;
    logic        EVT_REQ = 1'b0;
    logic [7:0]  EVT_PRE_ADDR = 8'h00;
    logic        EVT_PLASTIC = 1'b0;
    logic        EVT_ACK;
    logic        SPI_REQ = 1'b0;
    logic        SPI_WR = 1'b0;
    logic [12:0] SPI_ADDR = 13'h0;
    logic        SPI_ACK;
    logic [31:0] SPI_RDATA;
    logic [31:0] SYNARRAY_RDATA = 32'h0;
    logic        CTRL_SYNARRAY_CS;
    logic        CTRL_SYNARRAY_WE;
    logic [12:0] CTRL_SYNARRAY_ADDR;
    logic [7:0]  CTRL_PRE_EN;
    logic        SYN_WORD_VALID;
    logic [4:0]  SYN_WORD_IDX;
    logic [15:0] EVT_COUNT;

    syn_access_sequencer dut (
        .CLK(CLK), .RST(RST), .SPI_GATE_ACTIVITY_sync(SPI_GATE_ACTIVITY_sync),
        .EVT_REQ(EVT_REQ), .EVT_PRE_ADDR(EVT_PRE_ADDR), .EVT_PLASTIC(EVT_PLASTIC), .EVT_ACK(EVT_ACK),
        .SPI_REQ(SPI_REQ), .SPI_WR(SPI_WR), .SPI_ADDR(SPI_ADDR), .SPI_ACK(SPI_ACK), .SPI_RDATA(SPI_RDATA),
        .SYNARRAY_RDATA(SYNARRAY_RDATA), .CTRL_SYNARRAY_CS(CTRL_SYNARRAY_CS),
        .CTRL_SYNARRAY_WE(CTRL_SYNARRAY_WE), .CTRL_SYNARRAY_ADDR(CTRL_SYNARRAY_ADDR),
        .CTRL_PRE_EN(CTRL_PRE_EN), .SYN_WORD_VALID(SYN_WORD_VALID), .SYN_WORD_IDX(SYN_WORD_IDX),
        .EVT_COUNT(EVT_COUNT)
    );

    always #5 CLK = ~CLK;

    // Synaptic SRAM: registered read, write data stands in for sdsp_update / SPI mask output.
    logic [31:0] mem [8192];
    always @(posedge CLK) begin
        if (CTRL_SYNARRAY_CS) begin
            if (CTRL_SYNARRAY_WE) mem[CTRL_SYNARRAY_ADDR] <= $urandom;
            else                  SYNARRAY_RDATA <= mem[CTRL_SYNARRAY_ADDR];
        end
    end

    typedef struct packed {
        logic        cs, we;
        logic [12:0] addr;
        logic [7:0]  pe;
        logic        v;
        logic [4:0]  idx;
        logic        ea, sa, upd;
        logic [31:0] rd;
    } rec_t;

    rec_t        q[$];
    logic        pend_idle = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic [15:0] exp_cnt = 16'h0;
    logic        evt_dropped = 1'b0, spi_dropped = 1'b0;
    int          n_vec = 0, n_err = 0;
    int          stat_cyc, eack_at, sack_at, n_cs, n_we, n_pe, pe_bad, first_addr, last_addr;
    int          next_idx, idx_bad;

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
        if (n_err >= 100) begin
            summary();
            $finish;
        end
    endtask

    task automatic push_event(input logic [7:0] pre, input logic pl);
        rec_t r;
        for (int w = 0; w < 32; w++) begin
            r = '0; r.cs = 1'b1; r.addr = {pre, 5'(w)};
            if (pl) begin
                q.push_back(r);
                r.we = 1'b1; r.pe = 8'hFF; r.v = 1'b1; r.idx = 5'(w); r.ea = (w == 31);
                q.push_back(r);
            end else begin
                r.v = (w > 0); r.idx = 5'(w - 1);
                q.push_back(r);
            end
        end
        if (!pl) begin
            r = '0; r.v = 1'b1; r.idx = 5'd31; r.ea = 1'b1;
            q.push_back(r);
        end
    endtask

    task automatic push_spi(input logic [12:0] a, input logic wr);
        rec_t r;
        r = '0; r.cs = 1'b1; r.addr = a;
        q.push_back(r);
        if (wr) begin
            r.we = 1'b1; r.sa = 1'b1;
        end else begin
            r = '0; r.sa = 1'b1; r.upd = 1'b1; r.rd = mem[a];
        end
        q.push_back(r);
    endtask

    task automatic clear_stats();
        stat_cyc = 0; eack_at = -1; sack_at = -1; n_cs = 0; n_we = 0; n_pe = 0; pe_bad = 0;
        first_addr = -1; last_addr = -1; next_idx = 0; idx_bad = 0;
    endtask

    // One clock: arbitrate the idle cycle just observed, then compare the next cycle.
    task automatic cycle();
        rec_t        e;
        logic        was_idle;
        logic [30:0] ev, av;
        if (pend_idle) begin
            if (SPI_REQ && SPI_GATE_ACTIVITY_sync)       push_spi(SPI_ADDR, SPI_WR);
            else if (EVT_REQ && !SPI_GATE_ACTIVITY_sync) push_event(EVT_PRE_ADDR, EVT_PLASTIC);
        end
        evt_dropped = 1'b0; spi_dropped = 1'b0;
        @(negedge CLK);
        stat_cyc++;
        was_idle = (q.size() == 0);
        e = was_idle ? rec_t'('0) : q.pop_front();
        ev = {e.cs, e.we, e.addr, e.pe, e.v, (e.v ? e.idx : 5'd0), e.ea, e.sa};
        av = {CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_SYNARRAY_ADDR, CTRL_PRE_EN, SYN_WORD_VALID,
              (SYN_WORD_VALID ? SYN_WORD_IDX : 5'd0), EVT_ACK, SPI_ACK};
        check("outputs", 32'(av), 32'(ev));
        check("spi_rdata", SPI_RDATA, exp_rdata);
        check("evt_count", 32'(EVT_COUNT), 32'(exp_cnt));
        if (e.cs) begin
            n_cs++;
            if (first_addr < 0) first_addr = int'(e.addr);
            last_addr = int'(e.addr);
        end
        if (e.we) n_we++;
        if (e.pe != 8'h00) begin
            n_pe++;
            if (!e.we) pe_bad++;
        end
        if (e.v) begin
            if (int'(e.idx) != next_idx) idx_bad++;
            next_idx = (next_idx + 1) % 32;
        end
        if (e.upd) exp_rdata = e.rd;
        if (e.ea) begin
            EVT_REQ = 1'b0; evt_dropped = 1'b1; eack_at = stat_cyc;
`ifdef SYNSEQ_EVT_CNT_EN
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
        end
        if (e.sa) begin
            SPI_REQ = 1'b0; spi_dropped = 1'b1; sack_at = stat_cyc;
        end
        pend_idle = was_idle;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        RST = 1'b1; EVT_REQ = 1'b0; SPI_REQ = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_outputs", 32'({CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_SYNARRAY_ADDR, CTRL_PRE_EN,
              SYN_WORD_VALID, SYN_WORD_IDX, EVT_ACK, SPI_ACK}), 32'h0);
        check("reset_rdata_cnt", SPI_RDATA | 32'(EVT_COUNT), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        q.delete(); exp_rdata = 32'h0; exp_cnt = 16'h0; pend_idle = 1'b1;
    endtask

    logic [15:0] cnt_after3;

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        do_reset();

        // Non-plastic event on row 5
        SPI_GATE_ACTIVITY_sync = 1'b0;
        EVT_PRE_ADDR = 8'h05; EVT_PLASTIC = 1'b0; EVT_REQ = 1'b1;
        clear_stats(); run(40);
        check("A_ack_at", eack_at, 33);
        check("A_reads", n_cs, 32);
        check("A_writes", n_we, 0);
        check("A_first_addr", first_addr, 32'h0A0);
        check("A_last_addr", last_addr, 32'h0BF);
        check("A_idx_order", idx_bad, 0);

        // Plastic event on row 255
        EVT_PRE_ADDR = 8'hFF; EVT_PLASTIC = 1'b1; EVT_REQ = 1'b1;
        clear_stats(); run(70);
        check("B_ack_at", eack_at, 64);
        check("B_accesses", n_cs, 64);
        check("B_writes", n_we, 32);
        check("B_pre_en_wr", n_pe, 32);
        check("B_pre_en_rd", pe_bad, 0);
        check("B_first_addr", first_addr, 32'h1FE0);
        check("B_last_addr", last_addr, 32'h1FFF);
        check("B_idx_order", idx_bad, 0);

        // SPI read of a preloaded word
        mem[13'h0123] = 32'hDEADBEEF;
        SPI_GATE_ACTIVITY_sync = 1'b1;
        SPI_ADDR = 13'h0123; SPI_WR = 1'b0; SPI_REQ = 1'b1;
        clear_stats(); run(5);
        check("C_ack_at", sack_at, 2);
        check("C_writes", n_we, 0);
        check("C_rdata", SPI_RDATA, 32'hDEADBEEF);

        // Simultaneous event + SPI write with gate high: SPI first, event held until gate drops
        EVT_PRE_ADDR = 8'h22; EVT_PLASTIC = 1'b0; EVT_REQ = 1'b1;
        SPI_ADDR = 13'h0040; SPI_WR = 1'b1; SPI_REQ = 1'b1;
        clear_stats(); run(9);
        check("D_spi_ack_at", sack_at, 2);
        check("D_spi_writes", n_we, 1);
        check("D_spi_only", n_cs, 2);
        check("D_evt_stalled", eack_at, -1);
        SPI_GATE_ACTIVITY_sync = 1'b0;
        run(40);
        check("D_evt_ack_at", eack_at, 42);

        // Gate rises mid plastic event: event completes before SPI is served
        EVT_PRE_ADDR = 8'h33; EVT_PLASTIC = 1'b1; EVT_REQ = 1'b1;
        SPI_ADDR = 13'h1ABC; SPI_WR = 1'b0; SPI_REQ = 1'b1;
        clear_stats(); run(21);
        SPI_GATE_ACTIVITY_sync = 1'b1;
        run(50);
        check("E_evt_ack_at", eack_at, 64);
        check("E_spi_ack_at", sack_at, 67);

        // Reset while reading word 7
        SPI_GATE_ACTIVITY_sync = 1'b0;
        EVT_PRE_ADDR = 8'h44; EVT_PLASTIC = 1'b0; EVT_REQ = 1'b1;
        clear_stats(); run(8);
        check("F_pre_reset_reads", n_cs, 8);
        RST = 1'b1; EVT_REQ = 1'b0;
        #1;
        check("F_reset_outputs", 32'({CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_SYNARRAY_ADDR, CTRL_PRE_EN,
              SYN_WORD_VALID, SYN_WORD_IDX, EVT_ACK, SPI_ACK}), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        q.delete(); exp_rdata = 32'h0; exp_cnt = 16'h0; pend_idle = 1'b1;

        // Three events after reset
        for (int k = 0; k < 3; k++) begin
            EVT_PRE_ADDR = 8'($urandom); EVT_PLASTIC = 1'b0; EVT_REQ = 1'b1;
            run(36);
        end
`ifdef SYNSEQ_EVT_CNT_EN
        cnt_after3 = 16'd3;
`else
        cnt_after3 = 16'd0;
`endif
        check("G_evt_count", 32'(EVT_COUNT), 32'(cnt_after3));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!EVT_REQ && !evt_dropped && $urandom_range(0, 5) == 0) begin
                EVT_PRE_ADDR = 8'($urandom); EVT_PLASTIC = 1'($urandom); EVT_REQ = 1'b1;
            end
            if (!SPI_REQ && !spi_dropped && $urandom_range(0, 5) == 0) begin
                SPI_ADDR = 13'($urandom); SPI_WR = 1'($urandom); SPI_REQ = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) SPI_GATE_ACTIVITY_sync = ~SPI_GATE_ACTIVITY_sync;
            cycle();
        end

        summary();
        $finish;
    end

endmodule
